// File: rtl/reg_bank4_pkg.sv
// Shared constants and types for the four-entry register bank.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package reg_bank4_pkg;

    localparam int NUM_REGS = 4;
    localparam int IDX_W    = 2;

    typedef enum logic [1:0] {
        DUMP_IDLE = 2'd0,
        DUMP_SEND = 2'd1,
        DUMP_DONE = 2'd2
    } dump_state_t;

endpackage

// File: rtl/reg_mux4.sv
// DATA_W-wide 4:1 mux; s1 is the high select bit, s2 the low select bit.
// Latency: combinational.
// Backpressure: none.
module reg_mux4 #(
    parameter int DATA_W = 8
) (
    input  logic [DATA_W-1:0] d0,
    input  logic [DATA_W-1:0] d1,
    input  logic [DATA_W-1:0] d2,
    input  logic [DATA_W-1:0] d3,
    input  logic              s1,
    input  logic              s2,
    output logic [DATA_W-1:0] y
);

    always_comb begin
        case ({s1, s2})
            2'b00:   y = d0;
            2'b01:   y = d1;
            2'b10:   y = d2;
            default: y = d3;
        endcase
    end

endmodule

// File: rtl/reg_bank4.sv
// Four-register bank: one write port, two bypassed read ports, valid mask, and a register dump stream.
// Latency: reads combinational (write bypass same cycle); first dump beat the cycle after dump_start.
// Backpressure: dump beat held stable while dump_ready is low; 4 beats in 4 cycles with dump_ready high.
// Ports: clk/rst_n (sync, active-low); we/waddr/wdata write; ra_*/rb_* read ports;
//        clr clears valid bits; dump_start/dump_* stream; busy while a dump is in progress.
module reg_bank4
    import reg_bank4_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [1:0]        waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [1:0]        ra_sel,
    input  logic [1:0]        rb_sel,
    output logic [DATA_W-1:0] ra_data,
    output logic [DATA_W-1:0] rb_data,
    output logic              ra_valid,
    output logic              rb_valid,
    input  logic              clr,
    input  logic              dump_start,
    output logic [DATA_W-1:0] dump_data,
    output logic [1:0]        dump_idx,
    output logic              dump_valid,
    input  logic              dump_ready,
    output logic              busy
);

    logic [DATA_W-1:0]   regs [NUM_REGS];
    logic [NUM_REGS-1:0] valid_q;
    dump_state_t         state_q, state_d;
    logic [IDX_W-1:0]    idx_q, idx_d;

    logic [DATA_W-1:0]   mux_a, mux_b, mux_d;
    logic                hit_a, hit_b, in_send;

    // Storage and valid mask. When clr and we coincide, the later
    // assignment leaves only the freshly written bit set.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
            valid_q <= '0;
        end else begin
            if (we) begin
                regs[waddr] <= wdata;
            end
            if (clr) begin
                valid_q <= '0;
            end
            if (we) begin
                valid_q[waddr] <= 1'b1;
            end
        end
    end

    reg_mux4 #(.DATA_W(DATA_W)) u_mux_a (
        .d0(regs[0]), .d1(regs[1]), .d2(regs[2]), .d3(regs[3]),
        .s1(ra_sel[1]), .s2(ra_sel[0]), .y(mux_a)
    );

    reg_mux4 #(.DATA_W(DATA_W)) u_mux_b (
        .d0(regs[0]), .d1(regs[1]), .d2(regs[2]), .d3(regs[3]),
        .s1(rb_sel[1]), .s2(rb_sel[0]), .y(mux_b)
    );

    // The dump path reads storage directly (no bypass): a write to the
    // presented register shows up on dump_data from the following cycle.
    reg_mux4 #(.DATA_W(DATA_W)) u_mux_d (
        .d0(regs[0]), .d1(regs[1]), .d2(regs[2]), .d3(regs[3]),
        .s1(idx_q[1]), .s2(idx_q[0]), .y(mux_d)
    );

    // Write-to-read bypass: a same-cycle write wins over stored data and valid.
    assign hit_a    = we && (ra_sel == waddr);
    assign hit_b    = we && (rb_sel == waddr);
    assign ra_data  = hit_a ? wdata : mux_a;
    assign rb_data  = hit_b ? wdata : mux_b;
    assign ra_valid = hit_a | valid_q[ra_sel];
    assign rb_valid = hit_b | valid_q[rb_sel];

    // Dump FSM state register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= DUMP_IDLE;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    // Dump FSM next state. idx never wraps back into SEND: the beat at the
    // last index always exits to DONE.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        case (state_q)
            DUMP_IDLE: begin
                if (dump_start) begin
                    state_d = DUMP_SEND;
                    idx_d   = '0;
                end
            end
            DUMP_SEND: begin
                if (dump_ready) begin
                    if (idx_q == IDX_W'(NUM_REGS - 1)) begin
                        state_d = DUMP_DONE;
                        idx_d   = '0;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
            DUMP_DONE: begin
                state_d = DUMP_IDLE;
            end
            default: begin
                state_d = DUMP_IDLE;
                idx_d   = '0;
            end
        endcase
    end

    // Stream outputs are forced quiet while reset is held, so an abort
    // mid-dump cannot emit another beat.
    assign in_send    = rst_n && (state_q == DUMP_SEND);
    assign dump_valid = in_send;
    assign dump_data  = in_send ? mux_d : '0;
    assign dump_idx   = in_send ? idx_q : '0;
    assign busy       = rst_n && (state_q != DUMP_IDLE);

endmodule

// File: tb/tb_reg_bank4.sv
module tb_reg_bank4;

    localparam int K_RA_D = 0;
    localparam int K_RA_V = 1;
    localparam int K_RB_D = 2;
    localparam int K_RB_V = 3;
    localparam int K_DV   = 4;
    localparam int K_BUSY = 5;
    localparam int K_DD   = 6;
    localparam int K_DI   = 7;

    typedef struct {
        int         kind;
        logic [7:0] val;
    } probe_t;

    typedef struct {
        logic [1:0] idx;
        logic [7:0] data;
    } beat_t;

    logic       clk = 1'b0;
    logic       rst_n, we, clr, dump_start, dump_ready;
    logic [1:0] waddr, ra_sel, rb_sel;
    logic [7:0] wdata;
    logic [7:0] ra_data, rb_data, dump_data;
    logic       ra_valid, rb_valid, dump_valid, busy;
    logic [1:0] dump_idx;
    logic       chk_vld;

    probe_t probe_q[$];
    beat_t  dump_q[$];
    int     n_chk  = 0;
    int     n_pass = 0;

    always #5 clk = ~clk;

    reg_bank4 #(.DATA_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .we(we), .waddr(waddr), .wdata(wdata),
        .ra_sel(ra_sel), .rb_sel(rb_sel), .ra_data(ra_data), .rb_data(rb_data),
        .ra_valid(ra_valid), .rb_valid(rb_valid), .clr(clr),
        .dump_start(dump_start), .dump_data(dump_data), .dump_idx(dump_idx),
        .dump_valid(dump_valid), .dump_ready(dump_ready), .busy(busy)
    );

    function automatic string kname(int k);
        case (k)
            K_RA_D:  return "ra_data";
            K_RA_V:  return "ra_valid";
            K_RB_D:  return "rb_data";
            K_RB_V:  return "rb_valid";
            K_DV:    return "dump_valid";
            K_BUSY:  return "busy";
            K_DD:    return "dump_data";
            default: return "dump_idx";
        endcase
    endfunction

    function automatic logic [7:0] observe(int k);
        case (k)
            K_RA_D:  return ra_data;
            K_RA_V:  return {7'd0, ra_valid};
            K_RB_D:  return rb_data;
            K_RB_V:  return {7'd0, rb_valid};
            K_DV:    return {7'd0, dump_valid};
            K_BUSY:  return {7'd0, busy};
            K_DD:    return dump_data;
            default: return {6'd0, dump_idx};
        endcase
    endfunction

    // Monitor: probe checks on request, dump beats on every transfer.
    always @(negedge clk) begin
        probe_t     p;
        beat_t      b;
        logic [7:0] act;
        if (chk_vld) begin
            while (probe_q.size() != 0) begin
                p   = probe_q.pop_front();
                act = observe(p.kind);
                n_chk++;
                if (act === p.val) n_pass++;
                else $display("FAIL %s @%0t: got 0x%0h, want 0x%0h", kname(p.kind), $time, act, p.val);
            end
        end
        if (dump_valid === 1'b1 && dump_ready === 1'b1) begin
            n_chk++;
            if (dump_q.size() == 0) begin
                $display("FAIL dump_beat @%0t: unexpected beat idx=%0d data=0x%0h, want none",
                         $time, dump_idx, dump_data);
            end else begin
                b = dump_q.pop_front();
                if (dump_idx === b.idx && dump_data === b.data) n_pass++;
                else $display("FAIL dump_beat @%0t: got idx=%0d data=0x%0h, want idx=%0d data=0x%0h",
                              $time, dump_idx, dump_data, b.idx, b.data);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
        chk_vld = 1'b0;
    endtask

    task automatic probe(input int k, input logic [7:0] v);
        probe_t p;
        p.kind = k;
        p.val  = v;
        probe_q.push_back(p);
        chk_vld = 1'b1;
    endtask

    task automatic push_beat(input logic [1:0] i, input logic [7:0] d);
        beat_t b;
        b.idx  = i;
        b.data = d;
        dump_q.push_back(b);
    endtask

    initial begin
        rst_n = 1'b0; we = 1'b0; waddr = 2'd0; wdata = 8'd0; ra_sel = 2'd0; rb_sel = 2'd0;
        clr = 1'b0; dump_start = 1'b0; dump_ready = 1'b0; chk_vld = 1'b0;
        step();
        step();

        // Reset state, reset still held.
        probe(K_RA_D, 8'h00); probe(K_RA_V, 8'h00); probe(K_RB_V, 8'h00);
        probe(K_DV, 8'h00); probe(K_BUSY, 8'h00); probe(K_DD, 8'h00); probe(K_DI, 8'h00);
        step();
        rst_n = 1'b1;

        // Fill r0..r3 = 0x11..0x44.
        for (int i = 0; i < 4; i++) begin
            we    = 1'b1;
            waddr = i[1:0];
            wdata = 8'((i + 1) * 17);
            step();
        end
        we = 1'b0; ra_sel = 2'd2; rb_sel = 2'd3;
        probe(K_RA_D, 8'h33); probe(K_RA_V, 8'h01); probe(K_RB_D, 8'h44); probe(K_RB_V, 8'h01);
        step();

        // Same-cycle write bypass.
        we = 1'b1; waddr = 2'd1; wdata = 8'hA5; ra_sel = 2'd1; rb_sel = 2'd0;
        probe(K_RA_D, 8'hA5); probe(K_RA_V, 8'h01); probe(K_RB_D, 8'h11);
        step();
        wdata = 8'h22;
        probe(K_RA_D, 8'h22);
        step();
        we = 1'b0;
        probe(K_RA_D, 8'h22);
        step();

        // clr together with a write to r2.
        clr = 1'b1; we = 1'b1; waddr = 2'd2; wdata = 8'h33; ra_sel = 2'd0;
        probe(K_RA_V, 8'h01);
        step();
        clr = 1'b0; we = 1'b0; ra_sel = 2'd0; rb_sel = 2'd2;
        probe(K_RA_D, 8'h11); probe(K_RA_V, 8'h00); probe(K_RB_D, 8'h33); probe(K_RB_V, 8'h01);
        step();
        ra_sel = 2'd1; rb_sel = 2'd3;
        probe(K_RA_V, 8'h00); probe(K_RB_V, 8'h00);
        step();

        // Bypass makes an invalid register read valid in the write cycle.
        we = 1'b1; waddr = 2'd3; wdata = 8'h44; rb_sel = 2'd3;
        probe(K_RB_V, 8'h01); probe(K_RB_D, 8'h44);
        step();
        we = 1'b0;
        probe(K_RB_V, 8'h01);
        step();

        // Dump 1: full rate, plus a dump_start pulse mid-dump that must be ignored.
        dump_start = 1'b1; dump_ready = 1'b1;
        push_beat(2'd0, 8'h11); push_beat(2'd1, 8'h22); push_beat(2'd2, 8'h33); push_beat(2'd3, 8'h44);
        probe(K_BUSY, 8'h00);
        step();
        for (int c = 0; c < 4; c++) begin
            dump_start = (c == 1);
            probe(K_DV, 8'h01); probe(K_BUSY, 8'h01); probe(K_DI, 8'(c));
            step();
        end
        dump_start = 1'b0;
        probe(K_DV, 8'h00); probe(K_BUSY, 8'h01);
        step();
        probe(K_DV, 8'h00); probe(K_BUSY, 8'h00);
        step();

        // Dump 2: stall 3 cycles at idx 1, rewrite r1 during the stall.
        dump_start = 1'b1; dump_ready = 1'b1;
        push_beat(2'd0, 8'h11); push_beat(2'd1, 8'h5A); push_beat(2'd2, 8'h33); push_beat(2'd3, 8'h44);
        step();
        dump_start = 1'b0;
        probe(K_DI, 8'h00);
        step();
        dump_ready = 1'b0;
        for (int s = 0; s < 3; s++) begin
            we    = (s == 1);
            waddr = 2'd1;
            wdata = 8'h5A;
            probe(K_DV, 8'h01); probe(K_DI, 8'h01);
            probe(K_DD, (s == 2) ? 8'h5A : 8'h22);
            step();
        end
        we = 1'b0; dump_ready = 1'b1;
        probe(K_DI, 8'h01); probe(K_DD, 8'h5A);
        step();
        probe(K_DI, 8'h02); probe(K_DD, 8'h33);
        step();
        probe(K_DI, 8'h03); probe(K_DD, 8'h44);
        step();
        probe(K_DV, 8'h00); probe(K_BUSY, 8'h01);
        step();
        probe(K_BUSY, 8'h00);
        step();

        // Dump 3: reset asserted while idx 2 is presented.
        dump_start = 1'b1; dump_ready = 1'b1;
        push_beat(2'd0, 8'h11); push_beat(2'd1, 8'h5A);
        step();
        dump_start = 1'b0;
        step();
        probe(K_DI, 8'h01);
        step();
        dump_ready = 1'b0; rst_n = 1'b0;
        step();
        dump_ready = 1'b1; ra_sel = 2'd0; rb_sel = 2'd1;
        probe(K_DV, 8'h00); probe(K_BUSY, 8'h00);
        probe(K_RA_D, 8'h00); probe(K_RB_D, 8'h00); probe(K_RA_V, 8'h00);
        step();
        rst_n = 1'b1; ra_sel = 2'd2; rb_sel = 2'd3;
        probe(K_RA_D, 8'h00); probe(K_RB_D, 8'h00); probe(K_DV, 8'h00); probe(K_BUSY, 8'h00);
        step();
        step();
        probe(K_DV, 8'h00); probe(K_BUSY, 8'h00);
        step();
        step();

        n_chk++;
        if (dump_q.size() == 0) n_pass++;
        else $display("FAIL dump_count: %0d expected beats never seen, want 0", dump_q.size());

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/reg_bank4.md
REG_BANK4 -- requirements
Module: reg_bank4

Interface
REQ-001 The block SHALL have parameter DATA_W, default 8, register and bus width in bits.
REQ-002 The block SHALL have port clk, input, 1, sole clock; all state updates on rising edge.
REQ-003 The block SHALL have port rst_n, input, 1, reset, synchronous and active-low.
REQ-004 The block SHALL have port we, input, 1, write enable.
REQ-005 The block SHALL have port waddr, input, 2, write register index.
REQ-006 The block SHALL have port wdata, input, DATA_W, write data.
REQ-007 The block SHALL have ports ra_sel and rb_sel, input, 2 each, read-port A/B register index; bit 1 is the high select, bit 0 the low select.
REQ-008 The block SHALL have ports ra_data and rb_data, output, DATA_W each, read-port data feeding the downstream 4:1 operand mux.
REQ-009 The block SHALL have ports ra_valid and rb_valid, output, 1 each, selected register written since reset or clear.
REQ-010 The block SHALL have port clr, input, 1, clear all valid bits.
REQ-011 The block SHALL have port dump_start, input, 1, start a register dump.
REQ-012 The block SHALL have ports dump_data (output, DATA_W), dump_idx (output, 2), dump_valid (output, 1) and dump_ready (input, 1), forming the dump stream.
REQ-013 The block SHALL have port busy, output, 1, dump in progress.

Function
REQ-014 Storage SHALL be four DATA_W registers r0..r3 plus a 4-bit valid mask.
REQ-015 When we=1, the block SHALL write wdata into r[waddr] and set valid[waddr] at the clock edge.
REQ-016 Reads SHALL be combinational: ra_data=r[ra_sel] and rb_data=r[rb_sel].
REQ-017 On a write-to-read collision (we=1 and sel==waddr), the read port SHALL return wdata in the same cycle, with valid=1 (bypass).
REQ-018 On clr=1, all valid bits SHALL be zeroed at the next edge and register contents SHALL be kept.
REQ-019 When clr=1 and we=1 occur in the same cycle, valid SHALL equal only the bit for waddr, and the write SHALL complete.
REQ-020 The dump FSM SHALL have states IDLE, SEND and DONE.
REQ-021 In IDLE, dump_start=1 SHALL move the FSM to SEND with idx=0; dump_start SHALL be ignored outside IDLE.
REQ-022 In SEND, the block SHALL assert dump_valid with dump_data=r[idx] and dump_idx=idx.
REQ-023 In SEND, dump_data and dump_idx SHALL hold stable until a cycle with dump_valid&&dump_ready.
REQ-024 On each dump_valid&&dump_ready transfer, idx SHALL increment; the transfer at idx=3 SHALL move the FSM to DONE.
REQ-025 The block SHALL hold DONE for one cycle (busy=1, dump_valid=0), then return to IDLE.
REQ-026 busy SHALL be 1 in SEND and DONE.
REQ-027 A write during SEND to the register currently presented SHALL update dump_data from the next cycle; the presented value SHALL not be frozen.
REQ-028 The idx counter SHALL be 2 bits and SHALL NOT wrap back into SEND; four beats exactly per dump.
REQ-029 Minimum dump latency SHALL be: first beat valid the cycle after dump_start; four beats in four cycles with dump_ready held at 1.

Reset
REQ-030 On rst_n=0 at a clock edge, r0..r3 and the valid mask SHALL be cleared, the FSM SHALL enter IDLE and idx SHALL be 0.
REQ-031 During reset, dump_valid and busy SHALL be 0, and dump_data and dump_idx SHALL be 0.
REQ-032 Reset asserted mid-dump SHALL abort the dump with no further beats.
REQ-033 Reset SHALL take priority over we, clr and dump_start.

Structure
REQ-034 Package reg_bank4_pkg SHALL hold NUM_REGS=4, the IDX_W=2 constant and the dump state enum.
REQ-035 The block SHALL have one sub-module, reg_mux4, a DATA_W-wide 4:1 mux with s1/s2 selects, instantiated three times (read A, read B, dump).

Verification
REQ-036 Scenario: reset, then write r0..r3=0x11,0x22,0x33,0x44 -> ra_sel=2 returns 0x33 with ra_valid=1, and rb_sel=3 returns 0x44.
REQ-037 Scenario: we=1, waddr=1, wdata=0xA5, with ra_sel=1 in the same cycle -> ra_data=0xA5 in that cycle (bypass).
REQ-038 Scenario: clr=1 and we=1 (waddr=2) together -> next cycle valid mask=4'b0100, and r0 still reads 0x11 with ra_valid=0.
REQ-039 Scenario: dump_start with dump_ready=1 -> beats idx 0..3 carry 0x11,0x22,0x33,0x44 on consecutive cycles, then one DONE cycle, then busy=0.
REQ-040 Scenario: dump with dump_ready low for 3 cycles at idx=1 -> dump_data holds 0x22, and no beat is lost or duplicated.
REQ-041 Scenario: rst_n=0 asserted during idx=2 -> the next cycle shows dump_valid=0, busy=0 and all registers reading 0.
